rename_tag_alloc: RTL and testbench

Two-wide tag allocator and rename sequencer feeding `map_table`. Hands out in-order 8-bit RS/ROB tags to up to two dispatching instructions per cycle, recycles them on in-order retire, and owns misprediction recovery. During recovery it drives the map table's `clear_entries` and stalls dispatch. Tags follow the map-table format: `8'hFF` = NULL, bit 6 = ready flag (always 0 when issued), bits 5:0 = entry index.

---
 rtl/rename_tag_alloc.sv | 130 +++++++++++++
 tb/tb_rename_tag_alloc.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rename_tag_alloc.sv
// Two-wide in-order tag allocator with misprediction recovery feeding map_table.
// Optional: define TAG_ALLOC_PERF_EN to add the saturating stall_cycles_out counter.
module rename_tag_alloc #(
  parameter int DEPTH          = 32,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inst1_req,
  input  logic        inst2_req,
  input  logic        retire1_in,
  input  logic        retire2_in,
  input  logic        flush_in,
  output logic [7:0]  inst1_tag_out,
  output logic [7:0]  inst2_tag_out,
  output logic        dispatch_stall,
  output logic [31:0] clear_entries_out,
  output logic [6:0]  free_count_out
`ifdef TAG_ALLOC_PERF_EN
  ,
  output logic [31:0] stall_cycles_out
`endif
);

  localparam logic [5:0] PTR_MASK = 6'(DEPTH - 1);
  localparam logic [6:0] DEPTH_C  = 7'(DEPTH);
  localparam logic [3:0] REC_INIT = 4'(RECOVER_CYCLES);

  typedef enum logic {ST_RUN, ST_RECOVER} state_e;

  state_e     state_q, state_d;
  logic [5:0] head_q, head_d, tail_q, tail_d;
  logic [6:0] count_q, count_d;
  logic [3:0] rec_q, rec_d;

  logic [1:0] need, rcnt_raw, rcnt, granted;
  logic [6:0] free_now;
  logic       grant_ok;

  assign need     = 2'(inst1_req) + 2'(inst2_req);
  assign free_now = DEPTH_C - count_q;
  assign grant_ok = ({5'b0, need} <= free_now);
  assign rcnt_raw = 2'(retire1_in) + 2'(retire1_in & retire2_in);
  // Never retire more than is in flight, so count cannot underflow.
  assign rcnt     = (count_q < {5'b0, rcnt_raw}) ? count_q[1:0] : rcnt_raw;

  always_comb begin
    state_d           = state_q;
    head_d            = head_q;
    tail_d            = tail_q;
    count_d           = count_q;
    rec_d             = rec_q;
    granted           = 2'd0;
    inst1_tag_out     = 8'hFF;
    inst2_tag_out     = 8'hFF;
    dispatch_stall    = 1'b0;
    clear_entries_out = 32'h0;

    case (state_q)
      ST_RUN: begin
        if (flush_in) begin
          head_d         = 6'd0;
          tail_d         = 6'd0;
          count_d        = 7'd0;
          rec_d          = REC_INIT;
          state_d        = ST_RECOVER;
          dispatch_stall = (need != 2'd0);
        end else begin
          if (grant_ok) begin
            granted = need;
            if (inst1_req) inst1_tag_out = {2'b00, tail_q};
            if (inst2_req)
              inst2_tag_out = {2'b00, inst1_req ? ((tail_q + 6'd1) & PTR_MASK) : tail_q};
            tail_d = (tail_q + 6'(need)) & PTR_MASK;
          end else begin
            dispatch_stall = 1'b1;
          end
          head_d  = (head_q + 6'(rcnt)) & PTR_MASK;
          count_d = count_q + 7'(granted) - 7'(rcnt);
        end
      end
      ST_RECOVER: begin
        // Entry 0 is the zero register mapping and is never cleared.
        clear_entries_out = 32'hFFFF_FFFE;
        dispatch_stall    = (need != 2'd0);
        if (flush_in)         rec_d   = REC_INIT;
        else if (rec_q <= 4'd1) state_d = ST_RUN;
        else                  rec_d   = rec_q - 4'd1;
      end
      default: state_d = ST_RUN;
    endcase

    if (reset) begin
      inst1_tag_out     = 8'hFF;
      inst2_tag_out     = 8'hFF;
      dispatch_stall    = 1'b0;
      clear_entries_out = 32'h0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      head_q  <= 6'd0;
      tail_q  <= 6'd0;
      count_q <= 7'd0;
      rec_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rec_q   <= rec_d;
    end
  end

  assign free_count_out = DEPTH_C - count_q;

`ifdef TAG_ALLOC_PERF_EN
  logic [31:0] stall_cyc_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                     stall_cyc_q <= 32'h0;
    else if (dispatch_stall && (stall_cyc_q != '1)) stall_cyc_q <= stall_cyc_q + 32'd1;
  end

  assign stall_cycles_out = stall_cyc_q;
`endif

endmodule

// File: tb/tb_rename_tag_alloc.sv
// Directed bench for rename_tag_alloc (DEPTH 32, RECOVER_CYCLES 2).
module tb_rename_tag_alloc;

  logic        clock = 1'b0;
  logic        reset;
  logic        inst1_req, inst2_req, retire1_in, retire2_in, flush_in;
  logic [7:0]  inst1_tag_out, inst2_tag_out;
  logic        dispatch_stall;
  logic [31:0] clear_entries_out;
  logic [6:0]  free_count_out;
`ifdef TAG_ALLOC_PERF_EN
  logic [31:0] stall_cycles_out;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  rename_tag_alloc #(.DEPTH(32), .RECOVER_CYCLES(2)) dut (
    .clock             (clock),
    .reset             (reset),
    .inst1_req         (inst1_req),
    .inst2_req         (inst2_req),
    .retire1_in        (retire1_in),
    .retire2_in        (retire2_in),
    .flush_in          (flush_in),
    .inst1_tag_out     (inst1_tag_out),
    .inst2_tag_out     (inst2_tag_out),
    .dispatch_stall    (dispatch_stall),
    .clear_entries_out (clear_entries_out),
    .free_count_out    (free_count_out)
`ifdef TAG_ALLOC_PERF_EN
    ,
    .stall_cycles_out  (stall_cycles_out)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic r1, input logic r2, input logic rt1, input logic rt2, input logic fl);
    inst1_req  = r1;
    inst2_req  = r2;
    retire1_in = rt1;
    retire2_in = rt2;
    flush_in   = fl;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] t1, input logic [7:0] t2,
                         input logic st, input logic [31:0] clr);
    chk({tag, "_tag1"}, 32'(inst1_tag_out), 32'(t1));
    chk({tag, "_tag2"}, 32'(inst2_tag_out), 32'(t2));
    chk({tag, "_stall"}, 32'(dispatch_stall), 32'(st));
    chk({tag, "_clear"}, clear_entries_out, clr);
  endtask

  initial begin
    reset = 1'b1;
    drive(1, 1, 1, 1, 0);
    #2;
    chk_out("rst", 8'hFF, 8'hFF, 1'b0, 32'h0);
    chk("rst_free", 32'(free_count_out), 32'd32);
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;

    // Fill the whole ring, two tags per cycle.
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, 0, 0);
      #1;
      chk_out("fill", 8'(2 * i), 8'(2 * i + 1), 1'b0, 32'h0);
      tick();
      chk("fill_free", 32'(free_count_out), 32'(32 - 2 * (i + 1)));
    end

    drive(1, 1, 0, 0, 0);
    #1;
    chk_out("full", 8'hFF, 8'hFF, 1'b1, 32'h0);

    // Retire while full: freed tags only usable next cycle.
    drive(1, 1, 1, 1, 0);
    #1;
    chk_out("full_ret", 8'hFF, 8'hFF, 1'b1, 32'h0);
    tick();
    chk("full_ret_free", 32'(free_count_out), 32'd2);
    drive(1, 1, 0, 0, 0);
    #1;
    chk_out("wrap", 8'h00, 8'h01, 1'b0, 32'h0);
    tick();
    chk("wrap_free", 32'(free_count_out), 32'd0);

    // free = 1: pair is refused, single inst2 is granted the tail.
    drive(0, 0, 1, 0, 0);
    tick();
    chk("free1", 32'(free_count_out), 32'd1);
    drive(1, 1, 0, 0, 0);
    #1;
    chk_out("free1_pair", 8'hFF, 8'hFF, 1'b1, 32'h0);
    tick();
    chk("free1_hold", 32'(free_count_out), 32'd1);
    drive(0, 1, 0, 0, 0);
    #1;
    chk_out("free1_i2", 8'hFF, 8'h02, 1'b0, 32'h0);
    tick();
    chk("free1_i2_free", 32'(free_count_out), 32'd0);

    // retire2 alone does nothing; both retire two.
    drive(0, 0, 0, 1, 0);
    tick();
    chk("ret2_only", 32'(free_count_out), 32'd0);
    drive(0, 0, 1, 1, 0);
    tick();
    chk("ret_both", 32'(free_count_out), 32'd2);

    // Flush beats grant and retire; two RECOVER cycles follow.
    drive(1, 1, 1, 1, 1);
    tick();
    drive(1, 1, 1, 1, 0);
    #1;
    chk_out("rec1", 8'hFF, 8'hFF, 1'b1, 32'hFFFF_FFFE);
    chk("rec1_free", 32'(free_count_out), 32'd32);
    tick();
    #1;
    chk_out("rec2", 8'hFF, 8'hFF, 1'b1, 32'hFFFF_FFFE);
    chk("rec2_free", 32'(free_count_out), 32'd32);
    tick();
    drive(1, 1, 0, 0, 0);
    #1;
    chk_out("post_rec", 8'h00, 8'h01, 1'b0, 32'h0);
    tick();
    chk("post_rec_free", 32'(free_count_out), 32'd30);

    // Retire clipping at count 1 and 0.
    drive(0, 0, 1, 0, 0);
    tick();
    chk("clip_c1", 32'(free_count_out), 32'd31);
    drive(0, 0, 1, 1, 0);
    tick();
    chk("clip_c0", 32'(free_count_out), 32'd32);
    tick();
    chk("clip_empty", 32'(free_count_out), 32'd32);
    drive(1, 0, 0, 0, 0);
    #1;
    chk_out("i1_only", 8'h02, 8'hFF, 1'b0, 32'h0);
    tick();
    chk("i1_only_free", 32'(free_count_out), 32'd31);

    // Asynchronous reset in the middle of RECOVER.
    drive(0, 0, 0, 0, 1);
    tick();
    drive(1, 1, 0, 0, 0);
    #1;
    chk("mid_rec_clear", clear_entries_out, 32'hFFFF_FFFE);
    #1;
    reset = 1'b1;
    #1;
    chk_out("async_rst", 8'hFF, 8'hFF, 1'b0, 32'h0);
    chk("async_rst_free", 32'(free_count_out), 32'd32);
    #1;
    reset = 1'b0;
    #1;
    chk_out("after_rst", 8'h00, 8'h01, 1'b0, 32'h0);
    tick();
    chk("after_rst_free", 32'(free_count_out), 32'd30);
    drive(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
